// File: rtl/tt_um_tqv_peripheral_harness_nes_pkg.sv
// Shared constants for the NES controller harness: register map, bit indices,
// reader FSM states and the default NES clock divider.
package tt_um_tqv_peripheral_harness_nes_pkg;

  localparam int DIV_DEFAULT = 32;

  localparam logic [3:0] ADDR_BUTTONS = 4'h0;
  localparam logic [3:0] ADDR_CTRL    = 4'h1;
  localparam logic [3:0] ADDR_STATUS  = 4'h2;

  localparam int CTRL_AUTO_BIT    = 0;
  localparam int CTRL_START_BIT   = 1;
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_VALID_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_DONE
  } reader_state_t;

endpackage

// File: rtl/tt_um_tqv_peripheral_harness_nes_if.sv
// Tiny Tapeout style pin bundle: dedicated inputs, bidirectional inputs,
// outputs and bidirectional output enables.
interface tt_um_tqv_peripheral_harness_nes_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, output uio_in, input uo_out, input uio_out, input uio_oe);
  modport slave  (input ui_in, input uio_in, output uo_out, output uio_out, output uio_oe);
endinterface

// File: rtl/tt_um_tqv_peripheral_harness_nes_reader.sv
// NES controller reader: latch pulse, 8 clock pulses, serial data capture.
// nes_data must already be synchronized to clk.
module nes_reader
  import tt_um_tqv_peripheral_harness_nes_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       start,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic       busy,
  output logic       done,
  output logic [7:0] shift_data
);
  localparam int CW = $clog2(2 * DIV);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * DIV - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(DIV - 1);

  reader_state_t state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          latch_reg;
  logic          clk_reg;

  // Latch/clock registers change together with the state so the pins never glitch.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      latch_reg <= 1'b0;
      clk_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_LATCH;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            latch_reg <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (cnt_reg == LATCH_LAST) begin
            shift_reg[0] <= nes_data;
            cnt_reg      <= '0;
            latch_reg    <= 1'b0;
            state_reg    <= ST_CLK_LO;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_CLK_LO: begin
          if (cnt_reg == HALF_LAST) begin
            // Bit 0 was taken at the end of LATCH; the first low phase only waits.
            if (bit_reg != 3'd0) begin
              shift_reg[bit_reg] <= nes_data;
            end
            cnt_reg   <= '0;
            clk_reg   <= 1'b1;
            state_reg <= ST_CLK_HI;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_CLK_HI: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            clk_reg <= 1'b0;
            if (bit_reg == 3'd7) begin
              state_reg <= ST_DONE;
            end else begin
              bit_reg   <= bit_reg + 3'd1;
              state_reg <= ST_CLK_LO;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign nes_latch  = latch_reg;
  assign nes_clk    = clk_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_DONE);
  assign shift_data = shift_reg;

endmodule

// File: rtl/tt_um_tqv_peripheral_harness_nes.sv
// SPI-mode-0 register interface around an NES controller reader.
// Optional auto-poll feature selected by macro NES_AUTOPOLL_EN.
module tt_um_tqv_peripheral_harness_nes
  import tt_um_tqv_peripheral_harness_nes_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input logic clk,
  input logic rst_n,
  input logic ena,
  tt_um_tqv_peripheral_harness_nes_if.slave pins
);
  localparam int NSYNC = 4;
  // Lane order: 0 CS_n, 1 MOSI, 2 SCK, 3 NES data. CS_n and NES data idle high.
  localparam logic [NSYNC-1:0] SYNC_RST = 4'b1001;

  logic [NSYNC-1:0] sync_in;
  logic [NSYNC-1:0] sync_out;

  assign sync_in = {pins.ui_in[1], pins.uio_in[3], pins.uio_in[1], pins.uio_in[0]};

  for (genvar gi = 0; gi < NSYNC; gi++) begin : g_sync
    logic stage1_reg;
    logic stage2_reg;
    always_ff @(posedge clk) begin
      if (rst_n) begin
        stage1_reg <= SYNC_RST[gi];
        stage2_reg <= SYNC_RST[gi];
      end else begin
        stage1_reg <= sync_in[gi];
        stage2_reg <= stage1_reg;
      end
    end
    assign sync_out[gi] = stage2_reg;
  end

  logic cs_active, mosi_s, sck_s, nes_data_s;
  assign cs_active  = ~sync_out[0];
  assign mosi_s     = sync_out[1];
  assign sck_s      = sync_out[2];
  assign nes_data_s = sync_out[3];

  logic       sck_prev_reg;
  logic [3:0] bit_cnt_reg;
  logic [7:0] shift_in_reg;
  logic [7:0] cmd_reg;
  logic [7:0] miso_shift_reg;
  logic       miso_reg;
  logic [7:0] buttons_reg;
  logic       valid_reg;
  logic       start_pulse_reg;

  logic       sck_rise, sck_fall;
  logic [7:0] shift_next;
  logic [7:0] rd_data;
  logic       wr_en, rd_buttons_end;
  logic       reader_busy, reader_done, nes_latch, nes_clk;
  logic [7:0] reader_shift;
  logic       auto_start, auto_bit;

  assign sck_rise   = sck_s & ~sck_prev_reg;
  assign sck_fall   = ~sck_s & sck_prev_reg;
  assign shift_next = {shift_in_reg[6:0], mosi_s};

  // Side effects only happen on the 16th rising edge, so an aborted frame leaves no trace.
  assign wr_en          = cs_active && sck_rise && (bit_cnt_reg == 4'd15) && cmd_reg[7];
  assign rd_buttons_end = cs_active && sck_rise && (bit_cnt_reg == 4'd15) && !cmd_reg[7]
                          && (cmd_reg[3:0] == ADDR_BUTTONS);

  always_comb begin
    rd_data = 8'h00;
    case (shift_next[3:0])
      ADDR_BUTTONS: rd_data = buttons_reg;
      ADDR_CTRL:    rd_data[CTRL_AUTO_BIT] = auto_bit;
      ADDR_STATUS: begin
        rd_data[STATUS_BUSY_BIT]  = reader_busy;
        rd_data[STATUS_VALID_BIT] = valid_reg;
      end
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sck_prev_reg   <= 1'b0;
      bit_cnt_reg    <= '0;
      shift_in_reg   <= '0;
      cmd_reg        <= '0;
      miso_shift_reg <= '0;
      miso_reg       <= 1'b0;
    end else begin
      sck_prev_reg <= sck_s;
      if (!cs_active) begin
        bit_cnt_reg    <= '0;
        shift_in_reg   <= '0;
        miso_shift_reg <= '0;
        miso_reg       <= 1'b0;
      end else if (sck_rise) begin
        shift_in_reg <= shift_next;
        bit_cnt_reg  <= bit_cnt_reg + 4'd1;
        if (bit_cnt_reg == 4'd7) begin
          cmd_reg <= shift_next;
          if (!shift_next[7]) begin
            miso_shift_reg <= rd_data;
          end
        end
      end else if (sck_fall) begin
        miso_reg       <= miso_shift_reg[7];
        miso_shift_reg <= {miso_shift_reg[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      buttons_reg     <= '0;
      valid_reg       <= 1'b0;
      start_pulse_reg <= 1'b0;
    end else begin
      start_pulse_reg <= wr_en && (cmd_reg[3:0] == ADDR_CTRL) && shift_next[CTRL_START_BIT];
      if (rd_buttons_end) begin
        valid_reg <= 1'b0;
      end
      // A completed scan outranks a simultaneous read-clear.
      if (reader_done) begin
        buttons_reg <= ~reader_shift;
        valid_reg   <= 1'b1;
      end
    end
  end

`ifdef NES_AUTOPOLL_EN
  logic        auto_reg;
  logic [15:0] poll_cnt_reg;
  always_ff @(posedge clk) begin
    if (rst_n) begin
      auto_reg     <= 1'b0;
      poll_cnt_reg <= '0;
    end else begin
      poll_cnt_reg <= poll_cnt_reg + 16'd1;
      if (wr_en && (cmd_reg[3:0] == ADDR_CTRL)) begin
        auto_reg <= shift_next[CTRL_AUTO_BIT];
      end
    end
  end
  assign auto_start = auto_reg && (poll_cnt_reg == 16'hFFFF);
  assign auto_bit   = auto_reg;
`else
  assign auto_start = 1'b0;
  assign auto_bit   = 1'b0;
`endif

  nes_reader #(
    .DIV(DIV)
  ) u_reader (
    .clk       (clk),
    .srst      (rst_n),
    .start     (start_pulse_reg | auto_start),
    .nes_data  (nes_data_s),
    .nes_latch (nes_latch),
    .nes_clk   (nes_clk),
    .busy      (reader_busy),
    .done      (reader_done),
    .shift_data(reader_shift)
  );

  assign pins.uo_out  = {nes_clk, nes_latch, 5'b00000, valid_reg};
  assign pins.uio_out = {5'b00000, miso_reg, 2'b00};
  assign pins.uio_oe  = 8'b0000_0100;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, pins.ui_in[7:2], pins.ui_in[0], pins.uio_in[7:4],
                       pins.uio_in[2], cmd_reg[6:4]};

endmodule

// File: tb/tb_tt_um_tqv_peripheral_harness_nes.sv
// Directed bench: SPI host, behavioural NES controller (4021 shift register) and
// hand-computed expectations for the register map and scan behaviour.
module tb_tt_um_tqv_peripheral_harness_nes;
  localparam int DIV  = 32;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic sck = 1'b0;
  logic [7:0] pressed = 8'h00;

  int num_checks = 0;
  int num_fail = 0;

  logic [7:0] nes_sr = 8'hFF;
  logic       nes_clk_q = 1'b0;
  int         pulse_cnt = 0;
  int         latch_cycles = 0;

  tt_um_tqv_peripheral_harness_nes_if pins();

  assign pins.uio_in = {4'b0000, sck, 1'b0, mosi, cs_n};
  assign pins.ui_in  = {6'b000000, nes_sr[0], 1'b0};

  tt_um_tqv_peripheral_harness_nes #(
    .DIV(DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (1'b1),
    .pins (pins)
  );

  always #5 clk = ~clk;

  // Controller model: parallel load while latch is high, shift on clock rise.
  always @(negedge clk) begin
    if (pins.uo_out[6]) begin
      nes_sr       <= ~pressed;
      latch_cycles <= latch_cycles + 1;
    end else if (pins.uo_out[7] && !nes_clk_q) begin
      nes_sr    <= {1'b1, nes_sr[7:1]};
      pulse_cnt <= pulse_cnt + 1;
    end
    nes_clk_q <= pins.uo_out[7];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [7:0] cmd, input logic [7:0] dat, input int nbits,
                          output logic [7:0] rd);
    logic [15:0] tx;
    tx = {cmd, dat};
    rd = 8'h00;
    cs_n = 1'b0;
    wait_cyc(HALF);
    for (int j = 0; j < nbits; j++) begin
      mosi = tx[15-j];
      wait_cyc(HALF);
      if (j >= 8) rd[15-j] = pins.uio_out[2];
      sck = 1'b1;
      wait_cyc(HALF);
      sck = 1'b0;
    end
    wait_cyc(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_cyc(2 * HALF);
    $display("SPI cmd=%02h data=%02h bits=%0d miso=%02h", cmd, dat, nbits, rd);
  endtask

  task automatic spi_write(input logic [3:0] addr, input logic [7:0] dat);
    logic [7:0] dummy;
    spi_xfer({4'b1000, addr}, dat, 16, dummy);
  endtask

  task automatic spi_read(input logic [3:0] addr, output logic [7:0] rd);
    spi_xfer({4'b0000, addr}, 8'h00, 16, rd);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (pins.uo_out[0] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, pins.uo_out[0]}, 32'd1);
  endtask

  task automatic run_scan(input logic [7:0] btn, input string tag);
    logic [7:0] rd;
    int pbase, lbase;
    pressed = btn;
    pbase = pulse_cnt;
    lbase = latch_cycles;
    spi_write(4'h1, 8'h02);
    wait_valid({tag, "_valid"});
    check_eq({tag, "_pulses"}, pulse_cnt - pbase, 8);
    check_eq({tag, "_latch"}, latch_cycles - lbase, 2 * DIV);
    spi_read(4'h0, rd);
    check_eq({tag, "_buttons"}, {24'd0, rd}, {24'd0, btn});
    $display("SCAN %s pressed=%02h read=%02h", tag, btn, rd);
  endtask

  initial begin
    logic [7:0] rd;
    int pbase, lbase, n;

    rst_n = 1'b1;
    wait_cyc(5);
    check_eq("rst_uo_out", {24'd0, pins.uo_out}, 32'h00);
    check_eq("rst_uio_out", {24'd0, pins.uio_out}, 32'h00);
    check_eq("rst_uio_oe", {24'd0, pins.uio_oe}, 32'h04);
    rst_n = 1'b0;
    wait_cyc(10);
    check_eq("idle_uo_out", {24'd0, pins.uo_out}, 32'h00);
    check_eq("idle_uio_oe", {24'd0, pins.uio_oe}, 32'h04);
    spi_read(4'h0, rd);
    check_eq("idle_buttons", {24'd0, rd}, 32'h00);
    spi_read(4'h2, rd);
    check_eq("idle_status", {24'd0, rd}, 32'h00);

    // A + Start pressed
    run_scan(8'h09, "a_start");
    spi_read(4'h2, rd);
    check_eq("status_after_clear", {24'd0, rd}, 32'h00);
    check_eq("valid_pin_cleared", {31'd0, pins.uo_out[0]}, 32'd0);

    // Check STATUS while VALID is set, before the clearing read
    pressed = 8'h09;
    spi_write(4'h1, 8'h02);
    wait_valid("rescan_valid");
    spi_read(4'h2, rd);
    check_eq("status_valid", {24'd0, rd}, 32'h02);
    spi_read(4'h0, rd);
    check_eq("rescan_buttons", {24'd0, rd}, 32'h09);

    run_scan(8'h00, "released");
    run_scan(8'hFF, "all_pressed");
    run_scan(8'hA5, "pattern_a5");

    // Second START during a scan must be ignored
    pressed = 8'h3C;
    pbase = pulse_cnt;
    lbase = latch_cycles;
    spi_write(4'h1, 8'h02);
    spi_write(4'h1, 8'h02);
    spi_read(4'h2, rd);
    check_eq("status_busy", {24'd0, rd}, 32'h01);
    wait_valid("dbl_valid");
    wait_cyc(300);
    check_eq("dbl_pulses", pulse_cnt - pbase, 8);
    check_eq("dbl_latch", latch_cycles - lbase, 2 * DIV);
    spi_read(4'h0, rd);
    check_eq("dbl_buttons", {24'd0, rd}, 32'h3C);

    // Aborted write: 5 SCK cycles then CS_n rises
    pbase = pulse_cnt;
    spi_xfer(8'h81, 8'h02, 5, rd);
    wait_cyc(200);
    check_eq("abort_no_scan", pulse_cnt - pbase, 0);
    spi_read(4'h1, rd);
    check_eq("abort_ctrl", {24'd0, rd}, 32'h00);
    spi_read(4'h0, rd);
    check_eq("abort_next_read", {24'd0, rd}, 32'h3C);

    // Reset mid-scan
    pressed = 8'h55;
    spi_write(4'h1, 8'h02);
    n = 0;
    while (pins.uo_out[7] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("midscan_clk_high", {31'd0, pins.uo_out[7]}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midscan_rst_outputs", {24'd0, pins.uo_out}, 32'h00);
    check_eq("midscan_rst_oe", {24'd0, pins.uio_oe}, 32'h04);
    wait_cyc(4);
    rst_n = 1'b0;
    wait_cyc(4);
    pbase = pulse_cnt;
    wait_cyc(200);
    check_eq("post_rst_no_scan", pulse_cnt - pbase, 0);
    spi_read(4'h0, rd);
    check_eq("post_rst_buttons", {24'd0, rd}, 32'h00);
    spi_read(4'h2, rd);
    check_eq("post_rst_status", {24'd0, rd}, 32'h00);

`ifdef NES_AUTOPOLL_EN
    spi_write(4'h1, 8'h01);
    spi_read(4'h1, rd);
    check_eq("ctrl_auto", {24'd0, rd}, 32'h01);
    pbase = pulse_cnt;
    n = 0;
    while (pulse_cnt == pbase && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check_eq("autopoll_scan", {31'd0, pulse_cnt != pbase}, 32'd1);
    wait_valid("autopoll_valid");
    spi_write(4'h1, 8'h00);
`else
    pbase = pulse_cnt;
    spi_write(4'h1, 8'h01);
    spi_read(4'h1, rd);
    check_eq("ctrl_auto_off", {24'd0, rd}, 32'h00);
    wait_cyc(700);
    check_eq("no_autopoll", pulse_cnt - pbase, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_tqv_peripheral_harness_nes.md
TT_UM_TQV_PERIPHERAL_HARNESS_NES -- requirements
Module: tt_um_tqv_peripheral_harness

Interface
REQ-001 Parameter DIV, default 32: clk cycles per NES clock half-period; legal range 2..255.
REQ-002 clk  in  1  single system clock; all logic on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-high (asserted when 1), sampled on clk.
REQ-004 ena  in  1  design-selected flag; ignored.
REQ-005 ui_in  in  8  bit1 = NES serial data (buttons active-low); other bits ignored.
REQ-006 uio_in  in  8  host SPI: bit0 CS_n, bit1 MOSI, bit3 SCK; others ignored.
REQ-007 uo_out  out  8  bit6 NES latch, bit7 NES clock, bit0 data_valid flag, bits5:1 = 0.
REQ-008 uio_out  out  8  bit2 MISO; all other bits 0.
REQ-009 uio_oe  out  8  constant 8'b0000_0100.

Function
REQ-010 CS_n, SCK, MOSI and ui_in[1] each pass through a 2-flop synchronizer before use.
REQ-011 SPI mode 0, MSB first; MOSI sampled on synchronized SCK rising edge; MISO updated on SCK falling edge.
REQ-012 Transaction = 16 SCK cycles with CS_n low: command byte {W, 3'b0, ADDR[3:0]} then data byte.
REQ-013 W=1: data byte written to ADDR at the 16th rising SCK edge; W=0: register ADDR is captured after byte 1 and shifted out on MISO during byte 2.
REQ-014 CS_n rising edge aborts any partial transaction with no side effects; bit counter restarts at next CS_n fall.
REQ-015 Register map: 0x0 BUTTONS (RO, active-high, bit0 A,1 B,2 Select,3 Start,4 Up,5 Down,6 Left,7 Right); 0x1 CTRL (RW, bit0 AUTO, bit1 START write-1-pulse reads 0); 0x2 STATUS (RO, bit0 BUSY, bit1 VALID); unmapped reads return 0x00, writes ignored.
REQ-016 Reader FSM states IDLE, LATCH, CLK_LO, CLK_HI, DONE.
REQ-017 IDLE -> LATCH on START write, or on AUTO=1 (see REQ-027); latch high for 2*DIV cycles.
REQ-018 Bit k (k=0..7) sampled on the last cycle of LATCH (k=0) or of each CLK_LO phase (k=1..7); CLK_LO then CLK_HI each last DIV cycles; exactly 8 NES clock pulses issued.
REQ-019 After 8th CLK_HI: DONE for 1 cycle loads BUTTONS = ~shift_reg, sets VALID, returns to IDLE.
REQ-020 BUSY = 1 in every state except IDLE; START while BUSY is ignored.
REQ-021 VALID cleared by any SPI read of BUTTONS; a set in the same cycle as the clear wins.
REQ-022 uo_out[0] mirrors VALID; NES latch and clock are registered outputs (glitch-free).

Reset
REQ-023 While rst_n=1: FSM IDLE, BUTTONS 0x00, CTRL 0x00, VALID 0, SPI counter 0, uo_out 0x00, uio_out 0x00.
REQ-024 Reset mid-scan aborts immediately; latch and NES clock low the following cycle.
REQ-025 uio_oe = 8'b0000_0100 also during reset.

Configuration
REQ-026 Macro NES_AUTOPOLL_EN selects the auto-poll feature.
REQ-027 Defined: AUTO=1 starts a scan every 65536 clk cycles from a free-running counter (reset to 0) when IDLE. Undefined: CTRL bit0 reads 0, writes ignored, scans only via START.

Structure
REQ-028 Shared package holds register address constants, CTRL/STATUS bit indices, FSM state enum, DIV default.
REQ-029 One sub-module nes_reader (FSM, divider, shift register); SPI slave and register file stay in the top.

Verification
REQ-030 Reset, then idle -> uo_out=0x00, uio_oe=0x04, read 0x0 returns 0x00.
REQ-031 Write 0x1=0x02, model drives data A and Start pressed (bits 0,3 low) -> 8 clock pulses, 2*DIV latch, read 0x2=0x02, read 0x0=0x09, then 0x2=0x00.
REQ-032 All buttons released (data high) after scan -> BUTTONS 0x00; all pressed -> 0xFF.
REQ-033 START written twice during scan -> one scan of 8 pulses only; BUSY read as 1 mid-scan.
REQ-034 CS_n raised after 5 SCK cycles of a write to 0x1 -> CTRL unchanged, next full transaction works.
REQ-035 rst_n asserted mid-scan -> latch/clock 0 next cycle; with NES_AUTOPOLL_EN, AUTO=1 -> scan begins within 65536 cycles.
